// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction memory port
// and holds the IF/ID pipeline register plus a one-entry buffer for stalled returns.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  pc_keep_i,
  input  logic                  if_id_keep_i,
  input  logic                  branch_taken_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic [DATA_WIDTH-1:0] if_id_instr_o,
  output logic [ADDR_WIDTH-1:0] if_id_pc_o,
  output logic                  if_id_valid_o,
  output logic [1:0]            state_o
);

  // Handshake: imem_req_o is a registered level that stays high, with
  // imem_addr_o stable, until the memory returns a single-cycle imem_ack_i
  // carrying valid imem_rdata_i; an ack while imem_req_o is low is ignored.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    KILL = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] redir_q, redir_d;
  logic [DATA_WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic [ADDR_WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] id_instr_q, id_instr_d;
  logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
  logic                  id_valid_q, id_valid_d;

  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] target;
  state_e                next_fetch;
  logic                  unused_target_bits;

  assign pc_plus4           = pc_q + ADDR_WIDTH'(4);
  assign target             = {branch_target_i[ADDR_WIDTH-1:2], 2'b00};
  assign next_fetch         = pc_keep_i ? IDLE : BUSY;
  assign unused_target_bits = ^branch_target_i[1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_d     = redir_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    id_valid_d  = id_valid_q;

    // A redirect always flushes IF/ID; otherwise an unstalled IF/ID takes a bubble
    // unless a state below loads it with a real instruction.
    if (branch_taken_i) begin
      id_instr_d = '0;
      id_valid_d = 1'b0;
    end else if (!if_id_keep_i) begin
      id_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (branch_taken_i) pc_d = target;
        state_d = next_fetch;
      end
      BUSY: begin
        if (imem_ack_i) begin
          if (branch_taken_i) begin
            pc_d    = target;
            state_d = next_fetch;
          end else if (if_id_keep_i) begin
            buf_instr_d = imem_rdata_i;
            buf_pc_d    = pc_plus4;
            pc_d        = pc_plus4;
            state_d     = HOLD;
          end else begin
            id_instr_d = imem_rdata_i;
            id_pc_d    = pc_plus4;
            id_valid_d = 1'b1;
            pc_d       = pc_plus4;
            state_d    = next_fetch;
          end
        end else if (branch_taken_i) begin
          // The address must stay put until the ack, so park the target.
          redir_d = target;
          state_d = KILL;
        end
      end
      KILL: begin
        if (branch_taken_i) redir_d = target;
        if (imem_ack_i) begin
          pc_d    = branch_taken_i ? target : redir_q;
          state_d = next_fetch;
        end
      end
      HOLD: begin
        if (branch_taken_i) begin
          pc_d    = target;
          state_d = next_fetch;
        end else if (!if_id_keep_i) begin
          id_instr_d = buf_instr_q;
          id_pc_d    = buf_pc_q;
          id_valid_d = 1'b1;
          state_d    = next_fetch;
        end
      end
      default: state_d = IDLE;
    endcase

    req_d = (state_d == BUSY) || (state_d == KILL);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      redir_q     <= '0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      req_q       <= 1'b0;
      id_instr_q  <= '0;
      id_pc_q     <= '0;
      id_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      redir_q     <= redir_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      req_q       <= req_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_valid_q  <= id_valid_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign if_id_instr_o = id_instr_q;
  assign if_id_pc_o    = id_pc_q;
  assign if_id_valid_o = id_valid_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: startup, wait states, IF/ID stall with hold buffer,
// in-flight redirect, flush priority, PC stall, async reset and PC wrap.
module tb_fetch_unit;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        pc_keep_i = 1'b0;
  logic        if_id_keep_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc_o;
  logic        if_id_valid_o;
  logic [1:0]  state_o;

  logic auto_ack = 1'b1;
  logic man_ack  = 1'b0;

  int checks = 0;
  int errors = 0;

  // Clock and reset block
  always #5 clk_i = ~clk_i;

  // Memory model: zero-wait ack follows req in auto mode; data is a tag of the address
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_ack_i   = auto_ack ? imem_req_o : man_ack;
  assign imem_rdata_i = mem(imem_addr_o);

  fetch_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .pc_keep_i      (pc_keep_i),
    .if_id_keep_i   (if_id_keep_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ack_i     (imem_ack_i),
    .imem_rdata_i   (imem_rdata_i),
    .if_id_instr_o  (if_id_instr_o),
    .if_id_pc_o     (if_id_pc_o),
    .if_id_valid_o  (if_id_valid_o),
    .state_o        (state_o)
  );

  // Driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic br, input logic [31:0] tgt, input logic keep,
                       input logic pk, input logic ack);
    branch_taken_i  = br;
    branch_target_i = tgt;
    if_id_keep_i    = keep;
    pc_keep_i       = pk;
    man_ack         = ack;
  endtask

  // Scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [1:0] st, input logic req,
                            input logic [31:0] addr, input logic valid,
                            input logic [31:0] instr, input logic [31:0] pc);
    chk({tag, ".state"}, {30'd0, state_o}, {30'd0, st});
    chk({tag, ".req"}, {31'd0, imem_req_o}, {31'd0, req});
    chk({tag, ".addr"}, imem_addr_o, addr);
    chk({tag, ".valid"}, {31'd0, if_id_valid_o}, {31'd0, valid});
    chk({tag, ".instr"}, if_id_instr_o, instr);
    chk({tag, ".pc"}, if_id_pc_o, pc);
  endtask

  initial begin
    step();
    step();
    expect_all("reset", S_IDLE, 0, 32'h0, 0, 32'h0, 32'h0);
    rst_n_i = 1'b1;

    // Startup: request one edge after release, first instruction on the next
    step();
    expect_all("start", S_BUSY, 1, 32'h0, 0, 32'h0, 32'h0);
    step();
    expect_all("first", S_BUSY, 1, 32'h4, 1, mem(32'h0), 32'h4);

    // Three wait states on 0x4
    auto_ack = 1'b0;
    drive(0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_all("wait4", S_BUSY, 1, 32'h4, 0, mem(32'h0), 32'h4);
    end
    drive(0, 32'h0, 0, 0, 1);
    step();
    expect_all("late4", S_BUSY, 1, 32'h8, 1, mem(32'h4), 32'h8);

    // IF/ID stall covering the ack of 0x8; a stray ack in HOLD is ignored
    drive(0, 32'h0, 1, 0, 1);
    step();
    expect_all("hold1", S_HOLD, 0, 32'hC, 1, mem(32'h4), 32'h8);
    step();
    expect_all("hold2", S_HOLD, 0, 32'hC, 1, mem(32'h4), 32'h8);
    drive(0, 32'h0, 0, 0, 0);
    step();
    expect_all("release", S_BUSY, 1, 32'hC, 1, mem(32'h8), 32'hC);
    step();
    expect_all("waitC", S_BUSY, 1, 32'hC, 0, mem(32'h8), 32'hC);
    drive(0, 32'h0, 0, 0, 1);
    step();
    expect_all("instrC", S_BUSY, 1, 32'h10, 1, mem(32'hC), 32'h10);

    // Redirect to 0x103 while 0x10 is outstanding; its data must be dropped
    drive(1, 32'h103, 0, 0, 0);
    step();
    expect_all("kill1", S_KILL, 1, 32'h10, 0, 32'h0, 32'h10);
    drive(0, 32'h0, 0, 0, 0);
    step();
    expect_all("kill2", S_KILL, 1, 32'h10, 0, 32'h0, 32'h10);
    drive(0, 32'h0, 0, 0, 1);
    step();
    expect_all("redir", S_BUSY, 1, 32'h100, 0, 32'h0, 32'h10);
    step();
    expect_all("i100", S_BUSY, 1, 32'h104, 1, mem(32'h100), 32'h104);

    // Branch beats IF/ID keep in HOLD; buffered 0x104 is dropped
    drive(0, 32'h0, 1, 0, 1);
    step();
    expect_all("hold_b", S_HOLD, 0, 32'h108, 1, mem(32'h100), 32'h104);
    drive(1, 32'h200, 1, 0, 0);
    step();
    expect_all("flush", S_BUSY, 1, 32'h200, 0, 32'h0, 32'h104);
    drive(0, 32'h0, 0, 0, 1);
    step();
    expect_all("i200", S_BUSY, 1, 32'h204, 1, mem(32'h200), 32'h204);

    // PC stall with a request in flight: it completes, then no new request
    drive(0, 32'h0, 0, 1, 0);
    step();
    expect_all("pk_wait", S_BUSY, 1, 32'h204, 0, mem(32'h200), 32'h204);
    drive(0, 32'h0, 0, 1, 1);
    step();
    expect_all("pk_ack", S_IDLE, 0, 32'h208, 1, mem(32'h204), 32'h208);
    drive(0, 32'h0, 0, 1, 0);
    step();
    expect_all("pk_idle1", S_IDLE, 0, 32'h208, 0, mem(32'h204), 32'h208);
    drive(0, 32'h0, 0, 1, 1);
    step();
    expect_all("pk_idle2", S_IDLE, 0, 32'h208, 0, mem(32'h204), 32'h208);
    drive(0, 32'h0, 0, 0, 0);
    step();
    expect_all("pk_go", S_BUSY, 1, 32'h208, 0, mem(32'h204), 32'h208);

    // Asynchronous reset mid-request
    rst_n_i = 1'b0;
    #1;
    expect_all("async_rst", S_IDLE, 0, 32'h0, 0, 32'h0, 32'h0);
    step();
    expect_all("rst_hold", S_IDLE, 0, 32'h0, 0, 32'h0, 32'h0);
    rst_n_i = 1'b1;
    step();
    expect_all("restart", S_BUSY, 1, 32'h0, 0, 32'h0, 32'h0);

    // Branch with ack to an unaligned top address, then PC wraps to 0
    drive(1, 32'hFFFF_FFFF, 0, 0, 1);
    step();
    expect_all("wrap_br", S_BUSY, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
    drive(0, 32'h0, 0, 0, 1);
    step();
    expect_all("wrap", S_BUSY, 1, 32'h0, 1, mem(32'hFFFF_FFFC), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
